// File: rtl/shift_seq_pkg.sv
// Shared defaults and FSM state encoding for shift_sequencer, its shift stage and the bench.
package shift_seq_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SHW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int level_bits(input int shw);
        return (shw > 1) ? $clog2(shw) : 1;
    endfunction
endpackage

// File: rtl/shift_stage.sv
// One reusable log-shifter row: shifts right by 2^lvl_i, filling vacated top bits with fill_i.
module shift_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int LW    = 2
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [LW-1:0]    lvl_i,
    input  logic             en_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);
    logic [SHW-1:0] step;

    // Widening to 2*WIDTH with the fill pattern above keeps vacated bits correct for any level.
    always_comb begin
        step   = SHW'(1) << lvl_i;
        data_o = en_i ? WIDTH'({{WIDTH{fill_i}}, data_i} >> step) : data_i;
    end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter reusing one log-shift stage per cycle.
// Optional macro SHIFT_SKIP_EN: skip levels whose shift-amount bit is zero.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_sh,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int LW = level_bits(SHW);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] stageOut;

    shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .LW    (LW)
    ) u_stage (
        .data_i (data_q),
        .lvl_i  (lvl_q),
        .en_i   (amt_q[lvl_q]),
        .fill_i (fill_q),
        .data_o (stageOut)
    );

`ifdef SHIFT_SKIP_EN
    logic [SHW-1:0] scanVec;
    logic           scanHit;
    logic [LW-1:0]  scanLvl;

    // Priority-select the highest set amount bit: from in_sh at accept, below the current level otherwise.
    always_comb begin
        scanVec = '0;
        if (state_q == ST_IDLE) begin
            scanVec = in_sh;
        end else begin
            for (int i = 0; i < SHW; i++) begin
                scanVec[i] = amt_q[i] && (i < int'(lvl_q));
            end
        end
        scanHit = 1'b0;
        scanLvl = '0;
        for (int i = 0; i < SHW; i++) begin
            if (scanVec[i]) begin
                scanHit = 1'b1;
                scanLvl = LW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        res_d   = res_q;
        amt_d   = amt_q;
        lvl_d   = lvl_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    amt_d  = in_sh;
                    fill_d = in_arith & in_data[WIDTH-1];
`ifdef SHIFT_SKIP_EN
                    if (scanHit) begin
                        lvl_d   = scanLvl;
                        state_d = ST_SHIFT;
                    end else begin
                        res_d   = in_data;
                        state_d = ST_DONE;
                    end
`else
                    lvl_d   = LW'(SHW - 1);
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
                data_d = stageOut;
`ifdef SHIFT_SKIP_EN
                if (scanHit) begin
                    lvl_d = scanLvl;
                end else begin
                    res_d   = stageOut;
                    state_d = ST_DONE;
                end
`else
                if (lvl_q == '0) begin
                    res_d   = stageOut;
                    state_d = ST_DONE;
                end else begin
                    lvl_d = lvl_q - 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            res_q   <= '0;
            amt_q   <= '0;
            lvl_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            res_q   <= res_d;
            amt_q   <= amt_d;
            lvl_q   <= lvl_d;
            fill_q  <= fill_d;
        end
    end

    // The result register is separate from the working data so out_data keeps the last result.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = res_q;
endmodule
